// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the load/store unit.
// Size codes, FSM state type, byte-enable, replication and alignment helpers.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  function automatic logic [3:0] be_gen(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] repl(
    input logic [1:0]  size,
    input logic [31:0] d
  );
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Misaligned or illegal size: answered without touching memory.
  function automatic logic bad_access(
    input logic [1:0] size,
    input logic [1:0] a
  );
    return (size == SZ_ILL) ||
           (size == SZ_HALF && a[0]) ||
           (size == SZ_WORD && a != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select plus sign/zero extension.
// Ports: addr/size/uns select the lane of word; result is the 32-bit value.
module load_extend
  import mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{addr, 3'b000} +: 8];
    h = word[{addr[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: result = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: result = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: core request -> req/gnt/rvalid data-memory port.
// Ports: req_* from core, resp_* back, busy stall, mem_* to data memory.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  state_t      state, nxt;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q, ext;
  logic [15:0] cnt_q;
  logic        tmo, accept, in_req, done;

  assign tmo    = cnt_q >= LAST;
  assign accept = (state == S_IDLE) && req_valid;
  assign in_req = state == S_REQ;
  assign done   = state == S_DONE;

  load_extend u_ext (
    .addr   (addr_q[1:0]),
    .size   (size_q),
    .uns    (uns_q),
    .word   (mem_rdata),
    .result (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (req_valid)
          nxt = bad_access(req_size, req_addr[1:0]) ? S_DONE : S_REQ;
      S_REQ:
        if (mem_gnt)  nxt = we_q ? S_DONE : S_WAIT;
        else if (tmo) nxt = S_DONE;
      S_WAIT:
        if (mem_rvalid || tmo) nxt = S_DONE;
      S_DONE:
        nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= 32'b0;
        err_q   <= bad_access(req_size, req_addr[1:0]);
        cnt_q   <= 16'b0;
      end else if (state == S_REQ || state == S_WAIT) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (in_req && !mem_gnt && tmo)
        err_q <= 1'b1;
      // rvalid only counts while waiting; stale data is dropped.
      if (state == S_WAIT) begin
        if (mem_rvalid) rdata_q <= ext;
        else if (tmo)   err_q   <= 1'b1;
      end
    end
  end

  assign req_ready  = state == S_IDLE;
  assign busy       = state != S_IDLE;
  assign resp_valid = done;
  assign resp_err   = done & err_q;
  assign resp_rdata = done ? rdata_q : 32'b0;
  assign mem_req    = in_req;
  assign mem_we     = in_req & we_q;
  assign mem_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'b0;
  assign mem_be     = in_req ? be_gen(size_q, addr_q[1:0]) : 4'b0;
  assign mem_wdata  = in_req ? repl(size_q, wdata_q) : 32'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=16 and TIMEOUT=4 copies).
// Both copies share stimulus; the 4-cycle copy is checked in the timeout step.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'b0;

  logic        r_ready, r_valid, r_err, r_busy, r_req, r_we;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        t_ready, t_valid, t_err, t_busy, t_req, t_we;
  logic [31:0] t_rdata, t_addr, t_wdata;
  logic [3:0]  t_be;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(r_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(r_valid), .resp_rdata(r_rdata), .resp_err(r_err),
    .busy(r_busy), .mem_req(r_req), .mem_we(r_we),
    .mem_addr(r_addr), .mem_be(r_be), .mem_wdata(r_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.TIMEOUT(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(t_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(t_valid), .resp_rdata(t_rdata), .resp_err(t_err),
    .busy(t_busy), .mem_req(t_req), .mem_we(t_we),
    .mem_addr(t_addr), .mem_be(t_be), .mem_wdata(t_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one edge; returns in cycle 1 after accept.
  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd);
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(r_ready && t_ready) && n < 40) begin
      step();
      n++;
    end
    chk("idle_wait", {30'b0, r_ready, t_ready}, 32'h3);
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'b0, r_ready}, 32'h1);
    chk("rst_outs", {r_valid, r_err, r_busy, r_req, r_we, r_be},
        9'h0);
    chk("rst_bus", r_addr | r_wdata | r_rdata, 32'h0);
    rst_n = 1'b1;
    step();

    // store byte 0xAB @0x1003, zero-wait
    issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB);
    chk("st_req", {31'b0, r_req & r_we}, 32'h1);
    chk("st_be", {28'b0, r_be}, 32'h8);
    chk("st_wdata", r_wdata, 32'hABAB_ABAB);
    chk("st_addr", r_addr, 32'h0000_1000);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("st_resp", {30'b0, r_valid, r_err}, 32'h2);
    chk("st_rdata", r_rdata, 32'h0);
    step();
    chk("st_ready", {31'b0, r_ready}, 32'h1);

    // signed half load @0x2002
    issue(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0);
    chk("lh_be", {28'b0, r_be}, 32'hC);
    chk("lh_we", {31'b0, r_we}, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("lh_wait", {30'b0, r_req, r_valid}, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h80FF_1234;
    step();
    mem_rvalid = 1'b0;
    chk("lh_resp", {30'b0, r_valid, r_err}, 32'h2);
    chk("lh_rdata", r_rdata, 32'hFFFF_80FF);
    step();

    // unsigned half load @0x2002
    issue(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk("lhu_rdata", r_rdata, 32'h0000_80FF);
    step();

    // misaligned word @0x3001
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0);
    chk("mis_resp", {29'b0, r_valid, r_err, r_req}, 32'h6);
    chk("mis_rdata", r_rdata, 32'h0);
    step();
    chk("mis_noreq", {30'b0, r_req, r_ready}, 32'h1);

    // illegal size
    issue(1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0);
    chk("ill_resp", {29'b0, r_valid, r_err, r_req}, 32'h6);
    step();

    // grant delayed 3 cycles, rvalid 2 cycles later; signed byte @0x4001
    mem_rdata = 32'h1122_9988;
    issue(1'b0, 2'b00, 1'b0, 32'h0000_4001, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("gd_req", {29'b0, r_req, r_busy, r_valid}, 32'h6);
      chk("gd_addr", r_addr, 32'h0000_4000);
      chk("gd_be", {28'b0, r_be}, 32'h2);
      step();
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("gd_w1", {29'b0, r_req, r_busy, r_valid}, 32'h2);
    step();
    chk("gd_w2", {29'b0, r_req, r_busy, r_valid}, 32'h2);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk("gd_resp", {30'b0, r_valid, r_err}, 32'h2);
    chk("gd_rdata", r_rdata, 32'hFFFF_FF99);
    wait_idle();

    // grant never arrives: TIMEOUT=4 copy errors after 4 REQ cycles
    issue(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_req", {30'b0, t_req, t_valid}, 32'h2);
      step();
    end
    chk("to_resp", {29'b0, t_valid, t_err, t_req}, 32'h6);
    chk("to_rdata", t_rdata, 32'h0);
    step();
    chk("to_idle", {30'b0, t_req, t_ready}, 32'h1);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk("to_stray", {31'b0, t_valid}, 32'h0);
    wait_idle();

    // reset pulse while in WAIT
    issue(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rw_wait", {30'b0, r_busy, r_req}, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_async", {28'b0, r_ready, r_busy, r_valid, r_req}, 32'h8);
    #2;
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk("rw_noresp", {30'b0, r_valid, r_ready}, 32'h1);

    // normal load after reset
    mem_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
    chk("ar_addr", r_addr, 32'h0000_5000);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk("ar_resp", {30'b0, r_valid, r_err}, 32'h2);
    chk("ar_rdata", r_rdata, 32'hDEAD_BEEF);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
